// File: rtl/mmio_timer_intc_pkg.sv
// Shared constants for the memory-mapped timer / interrupt controller:
// register offsets, CTRL field positions, PEND bit indices and window size.
package mmio_timer_intc_pkg;

  // Address bits below this index select a register inside the window.
  localparam int WIN_BITS = 6;

  localparam logic [5:0] OFF_CTRL  = 6'h00;
  localparam logic [5:0] OFF_LOAD  = 6'h04;
  localparam logic [5:0] OFF_COUNT = 6'h08;
  localparam logic [5:0] OFF_PEND  = 6'h0C;
  localparam logic [5:0] OFF_MASK  = 6'h10;
  localparam logic [5:0] OFF_SWSET = 6'h14;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_RELOAD    = 1;
  localparam int CTRL_PRESC_LSB = 8;

  localparam int PEND_TIMER   = 0;
  localparam int PEND_EXT_LSB = 1;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer per line followed by a rising-edge detector;
// o_rise pulses for one cycle, two edges after the input is first sampled high.
module irq_edge_sync #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_sync_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_sync_d <= '0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/mmio_timer_intc.sv
// Bus-mapped prescaled down-counter plus interrupt controller (timer + NUM_EXT
// edge-captured lines). Reads are combinational; writes commit on the clock edge.
module mmio_timer_intc
  import mmio_timer_intc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          NUM_EXT   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               hit_o,
  input  logic [NUM_EXT-1:0] irq_i,
  output logic [NUM_EXT:0]   int_o
);

  localparam int NSRC = NUM_EXT + 1;

  // Bus protocol: no handshake. A cycle with ce_i & hit is an access; we_i
  // picks write (committed at the next edge) or read (data valid same cycle).
  logic              w_hit, w_wr, w_rd, w_sel_any;
  logic [5:0]        w_off;
  logic              w_wr_ctrl, w_wr_load, w_wr_count, w_wr_pend, w_wr_mask, w_wr_swset;
  logic              w_tick, w_tick_eff, w_expire;
  logic [NUM_EXT-1:0] w_rise;
  logic [NSRC-1:0]   w_w1c, w_set;
  logic              w_unused;

  logic              r_en, r_reload;
  logic [7:0]        r_presc, r_pcnt;
  logic [31:0]       r_load, r_count;
  logic [NSRC-1:0]   r_pend, r_mask, r_int;

  logic              w_en_nxt, w_reload_nxt;
  logic [7:0]        w_presc_nxt, w_pcnt_nxt;
  logic [31:0]       w_load_nxt, w_count_nxt;
  logic [NSRC-1:0]   w_pend_nxt, w_mask_nxt;

  irq_edge_sync #(.W(NUM_EXT)) u_irq_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (irq_i),
    .o_rise  (w_rise)
  );

  assign w_hit      = ce_i & (addr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
  assign w_off      = {addr_i[WIN_BITS-1:2], 2'b00};
  assign w_wr       = w_hit & we_i;
  assign w_rd       = w_hit & ~we_i;
  assign w_sel_any  = |sel_i;
  assign w_wr_ctrl  = w_wr & (w_off == OFF_CTRL);
  assign w_wr_load  = w_wr & (w_off == OFF_LOAD);
  assign w_wr_count = w_wr & (w_off == OFF_COUNT);
  assign w_wr_pend  = w_wr & (w_off == OFF_PEND);
  assign w_wr_mask  = w_wr & (w_off == OFF_MASK);
  assign w_wr_swset = w_wr & (w_off == OFF_SWSET);
  assign w_unused   = &{1'b0, addr_i[1:0]};

  // A bus write to COUNT, or one that clears EN, pre-empts the tick entirely.
  assign w_tick     = r_en & (r_pcnt == r_presc);
  assign w_tick_eff = w_tick & ~(w_wr_ctrl & sel_i[0] & ~wdata_i[CTRL_EN])
                             & ~(w_wr_count & w_sel_any);
  assign w_expire   = w_tick_eff & (r_count == '0);

  always_comb begin
    w_en_nxt     = r_en;
    w_reload_nxt = r_reload;
    w_presc_nxt  = r_presc;
    if (w_expire && !r_reload) w_en_nxt = 1'b0;
    if (w_wr_ctrl && sel_i[0]) begin
      w_en_nxt     = wdata_i[CTRL_EN];
      w_reload_nxt = wdata_i[CTRL_RELOAD];
    end
    if (w_wr_ctrl && sel_i[1]) w_presc_nxt = wdata_i[CTRL_PRESC_LSB +: 8];

    w_pcnt_nxt = (!r_en || !w_en_nxt || w_tick) ? 8'd0 : r_pcnt + 8'd1;
    w_load_nxt = w_wr_load ? lane_merge(r_load, wdata_i, sel_i) : r_load;

    w_count_nxt = r_count;
    if (w_wr_count && w_sel_any)           w_count_nxt = lane_merge(r_count, wdata_i, sel_i);
    else if (w_expire && r_reload)         w_count_nxt = r_load;
    else if (w_tick_eff && r_count != '0)  w_count_nxt = r_count - 32'd1;

    // Hardware and software sets are OR-ed in after the clear, so set wins.
    w_w1c = '0;
    w_set = '0;
    if (w_wr_pend && sel_i[0])  w_w1c = wdata_i[NSRC-1:0];
    if (w_wr_swset && sel_i[0]) w_set = wdata_i[NSRC-1:0];
    w_set[PEND_TIMER]              = w_set[PEND_TIMER] | w_expire;
    w_set[PEND_EXT_LSB +: NUM_EXT] = w_set[PEND_EXT_LSB +: NUM_EXT] | w_rise;
    w_pend_nxt = (r_pend & ~w_w1c) | w_set;
    w_mask_nxt = (w_wr_mask && sel_i[0]) ? wdata_i[NSRC-1:0] : r_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en     <= 1'b0;
      r_reload <= 1'b0;
      r_presc  <= '0;
      r_pcnt   <= '0;
      r_load   <= '0;
      r_count  <= '0;
      r_pend   <= '0;
      r_mask   <= '0;
      r_int    <= '0;
    end else begin
      r_en     <= w_en_nxt;
      r_reload <= w_reload_nxt;
      r_presc  <= w_presc_nxt;
      r_pcnt   <= w_pcnt_nxt;
      r_load   <= w_load_nxt;
      r_count  <= w_count_nxt;
      r_pend   <= w_pend_nxt;
      r_mask   <= w_mask_nxt;
      r_int    <= r_pend & r_mask;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (w_rd) begin
      case (w_off)
        OFF_CTRL:  rdata_o = {16'h0, r_presc, 6'h0, r_reload, r_en};
        OFF_LOAD:  rdata_o = r_load;
        OFF_COUNT: rdata_o = r_count;
        OFF_PEND:  rdata_o[NSRC-1:0] = r_pend;
        OFF_MASK:  rdata_o[NSRC-1:0] = r_mask;
        default:   rdata_o = '0;
      endcase
    end
  end

  assign hit_o = w_hit;
  assign int_o = r_int;

endmodule

// File: doc/mmio_timer_intc.md
Name: mmio_timer_intc

Overview:
Memory-mapped peripheral that sits as a responder on the core's data-RAM port (addr/data/we/sel/ce), in parallel with the data RAM. It contains a prescaled down-counting timer and a 6-source interrupt controller: the timer plus 5 external edge-captured lines. Its masked pending vector drives the core's int_i[5:0]. Reads are combinational, because the MEM stage samples read data in the same cycle; writes commit on the clock edge.

Parameters:
BASE_ADDR, 32'h1000_0000, base of the 64-byte register window; a hit is addr_i[31:6]==BASE_ADDR[31:6].
NUM_EXT, 5, number of external interrupt inputs; fixed so that NUM_EXT+1 = 6 = width of int_i.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-low reset.
ce_i  in  1  bus access strobe (ram_ce_o).
we_i  in  1  1 = write, 0 = read (ram_we_o).
addr_i  in  32  byte address (ram_addr_o); bits [1:0] are ignored.
sel_i  in  4  byte enables (ram_sel_o); sel_i[0] maps to data[7:0].
wdata_i  in  32  write data (ram_data_o).
rdata_o  out  32  read data, combinational.
hit_o  out  1  ce_i & address inside window, combinational; used by the top-level read mux.
irq_i  in  5  asynchronous external interrupt lines, rising-edge sensitive.
int_o  out  6  registered pend & mask, to the core's int_i.

Behaviour:
Register map (offset = addr_i[5:2]*4):
- 0x00 CTRL, RW: [0] EN; [1] RELOAD; [15:8] PRESC.
- 0x04 LOAD, RW, 32 bits.
- 0x08 COUNT, RW, 32 bits.
- 0x0C PEND, read / write-1-to-clear, bits [5:0]: bit0 = timer, bits[5:1] = irq_i[4:0].
- 0x10 MASK, RW, [5:0].
- 0x14 SWSET, write-1-to-set into PEND; reads 0.
- Other offsets: read 0, writes ignored.

Bus access:
- Write commits at the rising edge when ce_i & we_i & hit. Only byte lanes with their sel bit set are updated; unimplemented bits ignore writes and read 0.
- rdata_o = selected register when ce_i & ~we_i & hit, else 32'h0. Reads have no side effects.

Reset (rst=0, asynchronous):
- CTRL, LOAD, COUNT, PEND, MASK, prescaler count, and synchronizer flops all go to 0.
- int_o = 6'h0.

Prescaler:
- Counter pcnt runs while EN=1.
- tick = EN & (pcnt==PRESC); on tick, pcnt goes to 0, otherwise pcnt+1.
- Clearing EN resets pcnt to 0.

Timer, on each tick:
- COUNT!=0: COUNT goes to COUNT-1.
- COUNT==0: PEND[0] is set. If RELOAD=1, COUNT goes to LOAD; otherwise EN is cleared (one-shot).
- Period = (LOAD+1)*(PRESC+1) cycles.

External interrupts:
- Each irq_i bit passes a 2-flop synchronizer, then a rising-edge detector (sync & ~sync_d).
- A detected edge sets PEND[n+1].
- Latency from the irq_i rise to the PEND bit set is 3 clk edges; int_o follows 1 cycle later.

Simultaneous events:
- Hardware set (timer expiry, edge, SWSET) and W1C on the same bit in the same cycle: set wins.
- Bus write to COUNT and a tick in the same cycle: the bus write wins, and no expiry is evaluated that cycle.
- Bus write to CTRL that clears EN in a tick cycle: the write wins and no decrement occurs.

Other:
- int_o = registered (PEND & MASK), so it lags PEND/MASK changes by 1 cycle.
- A level held high on irq_i sets PEND only once, until it goes low and then high again.
- Reset asserted mid-count aborts the count immediately; nothing is pending after release.

Decomposition:
- Shared defines file gets: register offset constants, CTRL bit positions, PEND bit indices, and the window-size constant.
- One sub-module: irq_edge_sync, a parameterised-width 2-flop synchronizer plus rising-edge detector, instantiated for irq_i.

Test Plan:
1. Reset and idle: after reset, read all offsets -> every read returns 0, int_o=0; read of offset 0x18 -> 0, hit_o=1; read with address BASE+0x40 -> hit_o=0, rdata 0.
2. Auto-reload timer: write LOAD=3, COUNT=3, MASK=1, CTRL=0x0203 (PRESC=2, RELOAD=1, EN=1) -> PEND[0] sets every 12 cycles; int_o[0] rises 1 cycle after PEND[0]; write PEND=1 -> int_o[0] clears; the next expiry re-asserts it.
3. One-shot: CTRL=0x0001, COUNT=2 -> PEND[0] set on the 3rd cycle, CTRL reads 0x0000, COUNT stays 0, no further expiries.
4. Byte lanes: write 32'hAABBCCDD to LOAD with sel=4'b0010 -> LOAD reads 32'h0000CC00.
5. External edge: MASK=6'h3E, pulse irq_i[2] high for 1 cycle, then hold irq_i[2] high for 50 cycles -> PEND[3] set 3 edges after each rise and set once per rising edge; clear PEND[3] while held high -> PEND[3] stays 0.
6. Collisions: W1C PEND[0] in the same cycle as a timer expiry -> PEND[0]=1. SWSET=6'h20 -> PEND[5]=1, and int_o[5] follows only when MASK[5]=1. Deassert rst mid-count -> COUNT=0 and int_o=0.
